// File: rtl/fir_pkg.sv
// Shared widths, default coefficient set and output saturation for the 8-tap FIR.
package fir_pkg;

  localparam int unsigned NTAPS  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned ACC_W  = 35;

  localparam logic [NTAPS*COEF_W-1:0] COEFFS_DEFAULT = 128'h0001_0002_0003_0004_0004_0003_0002_0001;

  // Clamp the wide accumulator into the signed 32-bit range.
  function automatic logic signed [OUT_W-1:0] sat32(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W-OUT_W:0] top;
    top = acc[ACC_W-1:OUT_W-1];
    if (top == '0 || top == '1) begin
      return acc[OUT_W-1:0];
    end else if (acc[ACC_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/fir_mac_tap.sv
// One FIR tap: registered signed sample-by-coefficient product, held when disabled.
module fir_mac_tap
  import fir_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] Coef = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [OUT_W-1:0]  p_o
);

  logic signed [OUT_W-1:0] p_d, p_q;

  always_comb begin
    p_d = OUT_W'(x_i) * OUT_W'(Coef);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/fir_filter.sv
// 8-tap signed direct-form FIR, AXI4-Stream in/out, three-stage pipeline stalled by the sink.
module fir_filter
  import fir_pkg::*;
#(
  parameter logic [NTAPS*COEF_W-1:0] COEFFS = COEFFS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] s_axis_fir_tdata,
  input  logic                     s_axis_fir_tvalid,
  output logic                     s_axis_fir_tready,
  output logic signed [OUT_W-1:0]  m_axis_fir_tdata,
  output logic                     m_axis_fir_tvalid,
  output logic [3:0]               m_axis_fir_tkeep,
  input  logic                     m_axis_fir_tready
);

  logic en;
  logic accept;

  logic signed [DATA_W-1:0] x_d [NTAPS];
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic                     v1_q, v2_q;
  logic signed [OUT_W-1:0]  prod [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  tdata_d, tdata_q;
  logic                     tvalid_q;

  assign en                = m_axis_fir_tready;
  assign s_axis_fir_tready = en & ~reset;
  assign accept            = s_axis_fir_tvalid & s_axis_fir_tready;

  // Delay line only moves on an accepted sample; bubbles leave it intact.
  always_comb begin
    x_d = x_q;
    if (accept) begin
      x_d[0] = s_axis_fir_tdata;
      for (int i = 1; i < NTAPS; i++) begin
        x_d[i] = x_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= '{default: '0};
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en) begin
      x_q  <= x_d;
      v1_q <= accept;
      v2_q <= v1_q;
    end
  end

  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    fir_mac_tap #(
      .Coef(COEFFS[COEF_W*i +: COEF_W])
    ) u_tap (
      .clk_i(clk),
      .rst_i(reset),
      .en_i (en),
      .x_i  (x_q[i]),
      .p_o  (prod[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAPS; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
    tdata_d = sat32(acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (en) begin
      tdata_q  <= tdata_d;
      tvalid_q <= v2_q;
    end
  end

  assign m_axis_fir_tdata  = tdata_q;
  assign m_axis_fir_tvalid = tvalid_q;
  assign m_axis_fir_tkeep  = reset ? 4'h0 : 4'hF;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset, impulse, step, bubbles, back-pressure, saturation.
module tb_fir_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic [3:0]  m_tkeep;
  logic        m_tready = 1'b1;

  logic [15:0] sat_tdata = '0;
  logic        sat_s_tready;
  logic [31:0] sat_m_tdata;
  logic        sat_m_tvalid;
  logic [3:0]  sat_m_tkeep;

  int n_vec = 0;
  int n_err = 0;

  int imp_exp  [9] = '{31, 62, 93, 124, 124, 93, 62, 31, 0};
  int step_exp [9] = '{31, 93, 186, 310, 434, 527, 589, 620, 620};

  always #5 clk = ~clk;

  fir_filter dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_fir_tdata (s_tdata),
    .s_axis_fir_tvalid(s_tvalid),
    .s_axis_fir_tready(s_tready),
    .m_axis_fir_tdata (m_tdata),
    .m_axis_fir_tvalid(m_tvalid),
    .m_axis_fir_tkeep (m_tkeep),
    .m_axis_fir_tready(m_tready)
  );

  fir_filter #(
    .COEFFS({8{16'h7FFF}})
  ) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .s_axis_fir_tdata (sat_tdata),
    .s_axis_fir_tvalid(s_tvalid),
    .s_axis_fir_tready(sat_s_tready),
    .m_axis_fir_tdata (sat_m_tdata),
    .m_axis_fir_tvalid(sat_m_tvalid),
    .m_axis_fir_tkeep (sat_m_tkeep),
    .m_axis_fir_tready(m_tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    #1;
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tvalid", 32'(m_tvalid), 32'h0);
    check("rst_tkeep", 32'(m_tkeep), 32'h0);
    check("rst_s_tready", 32'(s_tready), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_tkeep", 32'(m_tkeep), 32'hF);
    check("post_rst_s_tready", 32'(s_tready), 32'h1);
  endtask

  initial begin
    // Impulse response
    do_reset();
    for (int i = 0; i < 11; i++) begin
      s_tdata  = (i == 0) ? 16'h001F : 16'h0000;
      s_tvalid = 1'b1;
      tick();
      if (i >= 2) begin
        check("imp_tvalid", 32'(m_tvalid), 32'h1);
        check("imp_tdata", m_tdata, 32'(imp_exp[i-2]));
      end else begin
        check("imp_lead_tvalid", 32'(m_tvalid), 32'h0);
      end
    end

    // Step response
    do_reset();
    for (int i = 0; i < 11; i++) begin
      s_tdata  = 16'h001F;
      s_tvalid = 1'b1;
      tick();
      if (i >= 2) begin
        check("step_tvalid", 32'(m_tvalid), 32'h1);
        check("step_tdata", m_tdata, 32'(step_exp[i-2]));
      end
    end

    // Five bubbles after the impulse sample
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_tdata  = (i == 0) ? 16'h001F : 16'h0000;
      s_tvalid = !(i >= 1 && i <= 5);
      tick();
      if (i == 2) begin
        check("bub_tvalid", 32'(m_tvalid), 32'h1);
        check("bub_tdata", m_tdata, 32'd31);
      end else if (i >= 8) begin
        check("bub_tvalid", 32'(m_tvalid), 32'h1);
        check("bub_tdata", m_tdata, 32'(imp_exp[i-7]));
      end else begin
        check("bub_gap_tvalid", 32'(m_tvalid), 32'h0);
      end
    end

    // Back-pressure during the step ramp
    do_reset();
    s_tdata  = 16'h001F;
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 2) check("bp_pre_tdata", m_tdata, 32'(step_exp[i-2]));
    end
    m_tready = 1'b0;
    #1;
    check("bp_s_tready", 32'(s_tready), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_tvalid", 32'(m_tvalid), 32'h1);
      check("bp_hold_tdata", m_tdata, 32'd93);
      check("bp_hold_s_tready", 32'(s_tready), 32'h0);
    end
    m_tready = 1'b1;
    #1;
    check("bp_rel_s_tready", 32'(s_tready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bp_post_tvalid", 32'(m_tvalid), 32'h1);
      check("bp_post_tdata", m_tdata, 32'(step_exp[2+k]));
    end

    // Reset mid-stream
    do_reset();
    s_tdata  = 16'h001F;
    s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid_pre_tdata", m_tdata, 32'd310);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tdata", m_tdata, 32'h0);
    check("mid_rst_tvalid", 32'(m_tvalid), 32'h0);
    check("mid_rst_tkeep", 32'(m_tkeep), 32'h0);
    check("mid_rst_s_tready", 32'(s_tready), 32'h0);
    tick();
    tick();
    reset   = 1'b0;
    s_tdata = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) begin
        check("mid_post_tvalid", 32'(m_tvalid), 32'h1);
        check("mid_post_tdata", m_tdata, 32'h0);
      end else begin
        check("mid_post_lead_tvalid", 32'(m_tvalid), 32'h0);
      end
    end

    // Saturation with all-0x7FFF coefficients
    do_reset();
    s_tvalid  = 1'b1;
    sat_tdata = 16'h7FFF;
    for (int i = 0; i < 12; i++) tick();
    check("sat_pos_tvalid", 32'(sat_m_tvalid), 32'h1);
    check("sat_pos_tdata", sat_m_tdata, 32'h7FFF_FFFF);
    sat_tdata = 16'h8000;
    for (int i = 0; i < 12; i++) tick();
    check("sat_neg_tdata", sat_m_tdata, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
